// File: rtl/descrypt_round_seq_if.sv
// Job/result handshake plus the round-loop taps between the sequencer and the E/S/P datapath.
// The sequencer takes the slave modport; the requester/datapath side takes the master modport.
interface descrypt_round_seq_if #(
  parameter int SALT_W = 12
);
  logic              start;
  logic [SALT_W-1:0] salt_in;
  logic [55:0]       key_in;
  logic [63:0]       block_in;
  logic              busy;
  logic [31:0]       R_out;
  logic [SALT_W-1:0] salt_out;
  logic [47:0]       subkey;
  logic [31:0]       f_in;
  logic [63:0]       result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output start, salt_in, key_in, block_in, f_in, result_ready,
    input  busy, R_out, salt_out, subkey, result, result_valid
  );

  modport slave (
    input  start, salt_in, key_in, block_in, f_in, result_ready,
    output busy, R_out, salt_out, subkey, result, result_valid
  );
endinterface

// File: rtl/descrypt_round_seq.sv
// Iterative DES round sequencer: one round per clock, 16*ITERATIONS cycles per job.
// Result is held in DONE until result_ready; start is only accepted in IDLE and never queued.
module descrypt_round_seq #(
  parameter int ITERATIONS = 25,
  parameter int SALT_W     = 12
) (
  input logic                 clk,
  input logic                 rst_n,
  descrypt_round_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [9:0]  ITER_LAST = 10'(ITERATIONS - 1);
  // Rounds 0, 1, 8 and 15 rotate by one; every other round rotates by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  logic [1:0]        state_q;
  logic [31:0]       l_q;
  logic [31:0]       r_q;
  logic [27:0]       c_q;
  logic [27:0]       d_q;
  logic [SALT_W-1:0] salt_q;
  logic [3:0]        round_q;
  logic [9:0]        iter_q;

  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [55:0] cd_rot;
  logic [47:0] subkey_c;

  always_comb begin
    c_rot = {c_q[25:0], c_q[27:26]};
    d_rot = {d_q[25:0], d_q[27:26]};
    if (SHIFT_ONE[round_q]) begin
      c_rot = {c_q[26:0], c_q[27]};
      d_rot = {d_q[26:0], d_q[27]};
    end
  end

  assign cd_rot = {c_rot, d_rot};

  // PC2 selection, bit index = 56 - table entry.
  assign subkey_c = {
    cd_rot[42], cd_rot[39], cd_rot[45], cd_rot[32], cd_rot[55], cd_rot[51], cd_rot[53], cd_rot[28],
    cd_rot[41], cd_rot[50], cd_rot[35], cd_rot[46], cd_rot[33], cd_rot[37], cd_rot[44], cd_rot[52],
    cd_rot[30], cd_rot[48], cd_rot[40], cd_rot[49], cd_rot[29], cd_rot[36], cd_rot[43], cd_rot[54],
    cd_rot[15], cd_rot[4],  cd_rot[25], cd_rot[19], cd_rot[9],  cd_rot[1],  cd_rot[26], cd_rot[16],
    cd_rot[5],  cd_rot[11], cd_rot[23], cd_rot[8],  cd_rot[12], cd_rot[7],  cd_rot[17], cd_rot[0],
    cd_rot[22], cd_rot[3],  cd_rot[10], cd_rot[14], cd_rot[6],  cd_rot[20], cd_rot[27], cd_rot[24]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      salt_q  <= '0;
      round_q <= '0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            l_q     <= bus.block_in[63:32];
            r_q     <= bus.block_in[31:0];
            c_q     <= bus.key_in[55:28];
            d_q     <= bus.key_in[27:0];
            salt_q  <= bus.salt_in;
            round_q <= '0;
            iter_q  <= '0;
          end
        end
        ST_RUN: begin
          c_q     <= c_rot;
          d_q     <= d_rot;
          round_q <= round_q + 4'd1;
          // Round 15 skips the swap so {L,R} already holds the pre-output for the next pass.
          if (round_q == 4'd15) begin
            l_q <= l_q ^ bus.f_in;
            if (iter_q == ITER_LAST) begin
              state_q <= ST_DONE;
            end else begin
              iter_q <= iter_q + 10'd1;
            end
          end else begin
            l_q <= r_q;
            r_q <= l_q ^ bus.f_in;
          end
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q == ST_RUN);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.R_out        = r_q;
  assign bus.salt_out     = salt_q;
  assign bus.subkey       = subkey_c;
  assign bus.result       = (state_q == ST_DONE) ? {l_q, r_q} : 64'd0;

endmodule

// File: tb/tb_descrypt_round_seq.sv
// Bench for descrypt_round_seq: three instances (1, 2, 25 iterations) driven by a textbook DES/crypt model.
module tb_descrypt_round_seq;

  localparam int ITS [3] = '{1, 2, 25};

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
    return o;
  endfunction

  // Salted E / S-boxes / P: salt bit j swaps E-output bits j and j+24.
  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [11:0] s, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] so;
    logic [31:0] o;
    logic [5:0]  six;
    logic        b;
    int          row;
    int          col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    for (int j = 0; j < 12; j++) begin
      if (s[j]) begin
        b = e[47-j]; e[47-j] = e[23-j]; e[23-j] = b;
      end
    end
    e = e ^ k;
    for (int bx = 0; bx < 8; bx++) begin
      six = e[47-6*bx -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      so[31-4*bx -: 4] = 4'(SBOX[bx][row*16+col]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = so[32-P_T[i]];
    return o;
  endfunction

  function automatic logic [15:0][47:0] key_sched(input logic [55:0] cd);
    logic [15:0][47:0] ks;
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int n = 0; n < SH_T[r]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[r] = pc2({c, d});
    end
    return ks;
  endfunction

  // Textbook DES: swap every round, undo the last swap, feed the pre-output back as the next input.
  function automatic logic [63:0] des_model(input logic [55:0] cd, input logic [63:0] blk,
                                            input logic [11:0] salt, input int iters);
    logic [15:0][47:0] ks;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    ks = key_sched(cd);
    l = blk[63:32];
    r = blk[31:0];
    for (int it = 0; it < iters; it++) begin
      for (int rr = 0; rr < 16; rr++) begin
        t = l ^ f_func(r, salt, ks[rr]);
        l = r;
        r = t;
      end
      t = l; l = r; r = t;
    end
    return {l, r};
  endfunction

  logic        clk;
  logic        rst_n;
  logic        start_a [3];
  logic        ready_a [3];
  logic [55:0] key_a   [3];
  logic [63:0] blk_a   [3];
  logic [11:0] salt_a  [3];
  logic        busy_a  [3];
  logic        rv_a    [3];
  logic [31:0] rout_a  [3];
  logic [11:0] sout_a  [3];
  logic [47:0] sk_a    [3];
  logic [63:0] res_a   [3];

  int n_err = 0;
  int n_chk = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    descrypt_round_seq_if #(.SALT_W(12)) ifc ();
    assign ifc.start        = start_a[g];
    assign ifc.salt_in      = salt_a[g];
    assign ifc.key_in       = key_a[g];
    assign ifc.block_in     = blk_a[g];
    assign ifc.result_ready = ready_a[g];
    assign ifc.f_in         = f_func(ifc.R_out, ifc.salt_out, ifc.subkey);
    assign busy_a[g]        = ifc.busy;
    assign rv_a[g]          = ifc.result_valid;
    assign rout_a[g]        = ifc.R_out;
    assign sout_a[g]        = ifc.salt_out;
    assign sk_a[g]          = ifc.subkey;
    assign res_a[g]         = ifc.result;
    descrypt_round_seq #(.ITERATIONS(ITS[g]), .SALT_W(12)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: state per instance, expected subkey per round, expected final result.
  int                m_st   [3];
  int                m_k    [3];
  logic [15:0][47:0] m_ks   [3];
  logic [11:0]       m_salt [3];
  logic [63:0]       m_res  [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_k[i] = 0; m_ks[i] = '0; m_salt[i] = '0; m_res[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          m_st[i] = 0;
        end else begin
          case (m_st[i])
            0: if (start_a[i]) begin
              m_st[i]   = 1;
              m_k[i]    = 0;
              m_ks[i]   = key_sched(key_a[i]);
              m_salt[i] = salt_a[i];
              m_res[i]  = des_model(key_a[i], blk_a[i], salt_a[i], ITS[i]);
            end
            1: begin
              m_k[i]++;
              if (m_k[i] == 16 * ITS[i]) m_st[i] = 2;
            end
            default: if (ready_a[i]) m_st[i] = 0;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("busy[%0d]", i), 64'(busy_a[i]), 64'(m_st[i] == 1));
          chk($sformatf("result_valid[%0d]", i), 64'(rv_a[i]), 64'(m_st[i] == 2));
          if (m_st[i] == 1) begin
            chk($sformatf("subkey[%0d] k=%0d", i, m_k[i]), 64'(sk_a[i]), 64'(m_ks[i][m_k[i] % 16]));
            chk($sformatf("salt_out[%0d]", i), 64'(sout_a[i]), 64'(m_salt[i]));
          end
          if (m_st[i] == 2) chk($sformatf("result[%0d]", i), res_a[i], m_res[i]);
        end
      end
    end
  end

  task automatic launch(input int i, input logic [55:0] k, input logic [63:0] b, input logic [11:0] s);
    @(negedge clk);
    key_a[i] = k; blk_a[i] = b; salt_a[i] = s; start_a[i] = 1'b1;
    @(negedge clk);
    start_a[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int bound, output int cnt);
    cnt = 0;
    while (!rv_a[i] && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
    if (!rv_a[i]) chk($sformatf("valid_timeout[%0d]", i), 64'(rv_a[i]), 64'd1);
  endtask

  task automatic retire(input int i);
    @(negedge clk);
    ready_a[i] = 1'b1;
    @(negedge clk);
    ready_a[i] = 1'b0;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s busy[%0d]", tag, i), 64'(busy_a[i]), 64'd0);
    chk($sformatf("%s rv[%0d]", tag, i), 64'(rv_a[i]), 64'd0);
    chk($sformatf("%s R_out[%0d]", tag, i), 64'(rout_a[i]), 64'd0);
    chk($sformatf("%s salt_out[%0d]", tag, i), 64'(sout_a[i]), 64'd0);
    chk($sformatf("%s subkey[%0d]", tag, i), 64'(sk_a[i]), 64'd0);
    chk($sformatf("%s result[%0d]", tag, i), res_a[i], 64'd0);
  endtask

  initial begin
    int          cnt;
    logic [63:0] cap;
    logic [47:0] sk0;
    logic [55:0] k;
    int          i;

    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      start_a[j] = 1'b0; ready_a[j] = 1'b0; key_a[j] = '0; blk_a[j] = '0; salt_a[j] = '0;
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) chk_zero(j, "reset");
    rst_n = 1'b1;

    chk("model_kat", fp(des_model(pc1(64'h133457799BBCDFF1), ip(64'h0123456789ABCDEF), 12'd0, 1)),
        64'h85E813540F0AB405);
    chk("model_zero", fp(des_model(56'd0, 64'd0, 12'd0, 1)), 64'h8CA64DE9C1B123A7);

    // Known-answer job, single iteration.
    launch(0, pc1(64'h133457799BBCDFF1), ip(64'h0123456789ABCDEF), 12'd0);
    wait_valid(0, 40, cnt);
    chk("kat_latency", 64'(cnt), 64'd16);
    chk("kat_result", fp(res_a[0]), 64'h85E813540F0AB405);
    retire(0);

    // Stall in DONE, ignored start during the stall, then start+ready together.
    launch(0, 56'({$urandom, $urandom}), {$urandom, $urandom}, 12'($urandom_range(0, 4095)));
    wait_valid(0, 40, cnt);
    cap = res_a[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 4) start_a[0] = 1'b1;
      if (c == 5) begin
        start_a[0] = 1'b0;
        chk("stall_start_ignored", 64'(busy_a[0]), 64'd0);
      end
      chk("stall_result", res_a[0], cap);
      chk("stall_valid", 64'(rv_a[0]), 64'd1);
    end
    @(negedge clk);
    start_a[0] = 1'b1; ready_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0; ready_a[0] = 1'b0;
    chk("retire_valid", 64'(rv_a[0]), 64'd0);
    chk("retire_start_ignored", 64'(busy_a[0]), 64'd0);
    @(negedge clk);
    chk("idle_after_retire", 64'(busy_a[0]), 64'd0);

    // Key-schedule wrap across an iteration boundary.
    k = 56'({$urandom, $urandom});
    launch(1, k, {$urandom, $urandom}, 12'($urandom_range(0, 4095)));
    sk0 = sk_a[1];
    repeat (16) @(negedge clk);
    chk("wrap_subkey", 64'(sk_a[1]), 64'(sk0));
    chk("wrap_cd", 64'({g_dut[1].u_dut.c_q, g_dut[1].u_dut.d_q}), 64'(k));
    wait_valid(1, 40, cnt);
    retire(1);

    // descrypt: password "A", salt 0, zero block.
    launch(2, pc1(64'h8200000000000000), 64'd0, 12'd0);
    wait_valid(2, 450, cnt);
    chk("crypt_latency", 64'(cnt), 64'd400);
    chk("crypt_result", fp(res_a[2]), fp(des_model(pc1(64'h8200000000000000), 64'd0, 12'd0, 25)));
    retire(2);

    for (int j = 0; j < 6; j++) begin
      i = j % 2;
      launch(i, 56'({$urandom, $urandom}), {$urandom, $urandom}, 12'($urandom_range(0, 4095)));
      wait_valid(i, 40, cnt);
      chk($sformatf("rand_latency[%0d]", j), 64'(cnt), 64'(16 * ITS[i]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      retire(i);
    end

    // Abort at round 7 of iteration 3, then a clean job on the same instance.
    launch(2, 56'({$urandom, $urandom}), {$urandom, $urandom}, 12'($urandom_range(1, 4095)));
    repeat (55) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(2, "abort");
    @(negedge clk);
    rst_n = 1'b1;
    k = 56'({$urandom, $urandom});
    cap = {$urandom, $urandom};
    launch(2, k, cap, 12'hA5C);
    wait_valid(2, 450, cnt);
    chk("post_abort_latency", 64'(cnt), 64'd400);
    chk("post_abort_result", res_a[2], des_model(k, cap, 12'hA5C, 25));
    retire(2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/descrypt_round_seq.md
Name:
descrypt_round_seq

Overview:
- Iterative DES round sequencer for the descrypt core. Performs one round per clock.
- Holds the L/R state and the C/D key-schedule state, and runs 16 rounds × ITERATIONS iterations.
- Drives R, salt and the 48-bit subkey to the salted E-expansion / S-box / P datapath, and takes back the 32-bit f-result in the same cycle.
- Sits directly upstream of the E-expansion stage and closes the round loop around it.

Parameters:
- ITERATIONS, 25, DES iterations per job (descrypt = 25); legal range 1..1023.
- SALT_W, 12, salt width (`SALT_MSB+1).

Ports:
- CLK  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; accepted only when busy=0 and result_valid=0.
- salt_in  in  SALT_W  salt for the job.
- key_in  in  56  post-PC1 key, {C[27:0], D[27:0]}.
- block_in  in  64  post-IP initial block, {L[31:0], R[31:0]}; zero for descrypt.
- busy  out  1  job in progress.
- R_out  out  32  current R register, to the E-expansion stage.
- salt_out  out  SALT_W  latched job salt, to the E-expansion stage.
- subkey  out  48  PC2 of the rotated C/D for the current round.
- f_in  in  32  P(S(E(R_out,salt_out) ^ subkey)); combinational return, valid in the same cycle.
- result  out  64  pre-FP output {L,R} after the final round.
- result_valid  out  1  result is held.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy=0, result_valid=0.
  - L, R, C, D, salt register, round counter and iteration counter cleared.
  - R_out=0, salt_out=0, result=0.
  - subkey = PC2 of zero C/D rotated by 1 = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch salt_in, key_in, block_in; round=0, iter=0; go to RUN; busy=1 from the next cycle.
  - start=0 → remain in IDLE.
- RUN (one round per cycle):
  - Shift amount by round 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C' and D' = left-rotate of C and D by that amount, computed combinationally from the registers.
  - subkey = PC2({C',D'}). C and D registers take C',D' at the clock edge.
  - Rounds 0..14: L←R, R←L^f_in.
  - Round 15: L←L^f_in, R←R (no swap), so the next iteration starts from {R16,L16}.
  - C/D total rotation per iteration is 28, so the registers return to their job-start value with no reload.
  - round increments and wraps 15→0; iter increments on that wrap.
  - Round 15 of iter=ITERATIONS-1 → DONE next cycle.
  - Job latency: exactly 16·ITERATIONS RUN cycles; result_valid rises on the following edge (400 cycles for ITERATIONS=25).
- DONE:
  - result={L,R}, result_valid=1, busy=0.
  - result held stable while result_ready=0.
  - On result_valid&result_ready → IDLE, result_valid=0 next cycle.
- start during RUN or DONE: ignored; it is not queued.
- start and result_ready both high in DONE: result is retired, start is ignored that cycle; the new job needs start in IDLE.
- f_in is sampled only in RUN; its value is don't-care in other states.
- R_out, salt_out and subkey change only at clock edges (registered sources); no combinational path from f_in to any output.
- rst_n low mid-RUN or mid-DONE: immediate abort, all outputs return to reset values, no partial result emitted.

Test Plan:
- DES known-answer test, ITERATIONS=1, salt=0, bench S/P model on f_in:
  - key 133457799BBCDFF1 and plaintext 0123456789ABCDEF, both passed through bench PC1/IP.
  - Required: FP(result) = 85E813540F0AB405; result_valid exactly 16 cycles after the start edge.
- Schedule wrap, ITERATIONS=2, any key:
  - Required: subkey in round 0 of iteration 1 equals round-0 subkey of iteration 0.
  - Required: C/D registers equal key_in after cycle 16.
- descrypt, ITERATIONS=25:
  - Inputs: password "A" (key bytes 82 00…, through PC1), salt 12'h000, block 0; bench model includes the salted E.
  - Required: FP(result) matches the bench crypt(3) reference; latency 400 cycles.
- Handshake:
  - Hold result_ready=0 for 10 cycles after result_valid → result and result_valid stable.
  - Pulse start during the stall → ignored, busy stays 0.
  - result_ready=1 → IDLE next cycle.
- Reset mid-run:
  - Deassert rst_n at round 7 of iteration 3 → busy=0, result_valid=0, all outputs 0 asynchronously.
  - A new start after release → correct result, with no state left from the aborted job.
